// File: rtl/team_09_pkg.sv
// Shared types and constants for the snake-game input path.
// Direction encoding is chosen so that the opposite direction is the LSB inverted.
package team_09_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  // 10 ms of stable input at 12 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 120000;

  function automatic dir_t opposite(input dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One push button: 2-flop synchronizer, counting debouncer, and a
// registered one-cycle pulse on each accepted press (rising stable level).
module button_debouncer
  import team_09_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else if (en) begin
      // synchronizer stage boundary: sync_p1 is the first safe copy of raw_i
      sync_p0 <= raw_i;
      sync_p1 <= sync_p0;
      press_q <= 1'b0;
      if (sync_p1 == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q >= CNT_LAST) begin
        level_q <= ~level_q;
        cnt_q   <= '0;
        press_q <= ~level_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      press_q <= 1'b0;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q & en;

endmodule

// File: rtl/direction_input_conditioner.sv
// Debounces the six game buttons and turns direction presses into a pending
// direction that is committed to the snake on each game-step strobe.
module direction_input_conditioner
  import team_09_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       en,
  input  logic [3:0] pb_dir_i,
  input  logic       pb_mode_i,
  input  logic       pb_obs_i,
  input  logic       sync_i,
  output logic [1:0] dir_o,
  output logic [1:0] dir_pending_o,
  output logic       mode_pulse_o,
  output logic       obs_pulse_o,
  output logic       any_press_o
);

  logic [5:0] raw;
  logic [5:0] level;
  logic [5:0] press;
  logic [5:0] pulse;
  logic       sel_vld;
  dir_t       sel_dir;
  logic       accept;
  dir_t       dir_q;
  dir_t       pend_q;

  assign raw = {pb_obs_i, pb_mode_i, pb_dir_i};

  for (genvar i = 0; i < 6; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk    (clk),
      .nrst   (nrst),
      .en     (en),
      .raw_i  (raw[i]),
      .level_o(level[i]),
      .press_o(press[i])
    );
  end

  // a press pulse always coincides with its debounced level being high
  assign pulse = press & level;

  always_comb begin
    sel_vld = 1'b0;
    sel_dir = DIR_RIGHT;
    if (pulse[3]) begin
      sel_vld = 1'b1;
      sel_dir = DIR_UP;
    end else if (pulse[2]) begin
      sel_vld = 1'b1;
      sel_dir = DIR_DOWN;
    end else if (pulse[1]) begin
      sel_vld = 1'b1;
      sel_dir = DIR_LEFT;
    end else if (pulse[0]) begin
      sel_vld = 1'b1;
      sel_dir = DIR_RIGHT;
    end
    accept = sel_vld && (sel_dir != opposite(dir_q));
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dir_q  <= DIR_RIGHT;
      pend_q <= DIR_RIGHT;
    end else if (en) begin
      // commit stage boundary: the old pending value moves to dir_q
      if (sync_i) begin
        dir_q <= pend_q;
      end
      if (accept) begin
        pend_q <= sel_dir;
      end
    end
  end

  assign dir_o         = dir_q;
  assign dir_pending_o = pend_q;
  assign mode_pulse_o  = pulse[4];
  assign obs_pulse_o   = pulse[5];
  assign any_press_o   = |pulse;

endmodule

// File: tb/tb_direction_input_conditioner.sv
// Directed and randomized bench for direction_input_conditioner with a
// behavioural model of the debounce and direction-commit rules.
module tb_direction_input_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       en = 1'b1;
  logic [3:0] pb_dir = 4'b0000;
  logic       pb_mode = 1'b0;
  logic       pb_obs = 1'b0;
  logic       sync = 1'b0;
  logic [1:0] dir_o;
  logic [1:0] dir_pending_o;
  logic       mode_pulse_o;
  logic       obs_pulse_o;
  logic       any_press_o;

  int checks = 0;
  int errors = 0;

  bit [5:0] m_s0, m_s1, m_lvl, m_press;
  int       m_run[6];
  bit [1:0] m_dir, m_pend;

  direction_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .en           (en),
    .pb_dir_i     (pb_dir),
    .pb_mode_i    (pb_mode),
    .pb_obs_i     (pb_obs),
    .sync_i       (sync),
    .dir_o        (dir_o),
    .dir_pending_o(dir_pending_o),
    .mode_pulse_o (mode_pulse_o),
    .obs_pulse_o  (obs_pulse_o),
    .any_press_o  (any_press_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s0 = '0; m_s1 = '0; m_lvl = '0; m_press = '0;
    for (int i = 0; i < 6; i++) m_run[i] = 0;
    m_dir = 2'b11;
    m_pend = 2'b11;
  endtask

  // One rising edge of the reference behaviour, using pre-edge inputs.
  task automatic model_edge(input bit [5:0] raw, input bit e, input bit s);
    bit [1:0] old_dir, sel;
    bit       found;
    bit [5:0] new_press;
    if (!e) begin
      m_press = '0;
      return;
    end
    old_dir = m_dir;
    found = 1'b0;
    sel = 2'b00;
    for (int i = 3; i >= 0; i--) begin
      if (!found && m_press[i]) begin
        found = 1'b1;
        sel = 2'(3 - i);
      end
    end
    if (s) m_dir = m_pend;
    if (found && sel != (old_dir ^ 2'b01)) m_pend = sel;
    new_press = '0;
    for (int i = 0; i < 6; i++) begin
      if (m_s1[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_lvl[i] = ~m_lvl[i];
          m_run[i] = 0;
          new_press[i] = m_lvl[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s1 = m_s0;
    m_s0 = raw;
    m_press = new_press;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dir"}, dir_o, m_dir);
    chk({tag, ".pend"}, dir_pending_o, m_pend);
    chk({tag, ".mode"}, mode_pulse_o, m_press[4] & en);
    chk({tag, ".obs"}, obs_pulse_o, m_press[5] & en);
    chk({tag, ".any"}, any_press_o, (|m_press) & en);
  endtask

  task automatic step(input string tag, input int n = 1);
    for (int k = 0; k < n; k++) begin
      bit [5:0] raw;
      bit e, s, r;
      raw = {pb_obs, pb_mode, pb_dir};
      e = en; s = sync; r = nrst;
      @(posedge clk);
      if (!r) model_reset();
      else model_edge(raw, e, s);
      #1;
      check_all(tag);
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  task automatic strobe(input string tag);
    sync = 1'b1;
    step(tag);
    sync = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    do_reset();
    chk("reset_dir", dir_o, 2'b11);
    chk("reset_pend", dir_pending_o, 2'b11);
    chk("reset_any", any_press_o, 1'b0);

    // up held: pulse after edge 6, pending UP one edge later, none on release
    pb_dir = 4'b1000;
    step("up_hold", 5);
    chk("up_no_early_pulse", any_press_o, 1'b0);
    step("up_edge6");
    chk("up_pulse", any_press_o, 1'b1);
    step("up_edge7");
    chk("up_single_pulse", any_press_o, 1'b0);
    chk("up_pending", dir_pending_o, 2'b00);
    pb_dir = 4'b0000;
    step("up_release", 10);

    // bouncing up never debounces
    do_reset();
    for (int i = 0; i < 10; i++) begin
      pb_dir = (i % 2 == 0) ? 4'b1000 : 4'b0000;
      step("bounce");
    end
    pb_dir = 4'b0000;
    step("bounce_low", 8);
    chk("bounce_pend", dir_pending_o, 2'b11);

    // left rejected against RIGHT, down accepted and committed
    do_reset();
    pb_dir = 4'b0010;
    step("left", 7);
    pb_dir = 4'b0000;
    step("left_rel", 6);
    strobe("left_sync");
    chk("left_dir", dir_o, 2'b11);
    chk("left_pend", dir_pending_o, 2'b11);
    pb_dir = 4'b0100;
    step("down", 7);
    pb_dir = 4'b0000;
    step("down_rel", 6);
    strobe("down_sync");
    chk("down_dir", dir_o, 2'b01);

    // up+right with dir DOWN: up wins and is rejected
    pb_dir = 4'b1001;
    step("upright", 7);
    chk("upright_pend", dir_pending_o, 2'b01);
    pb_dir = 4'b0000;
    step("upright_rel", 6);
    do_reset();
    pb_dir = 4'b1010;
    step("upleft", 7);
    chk("upleft_pend", dir_pending_o, 2'b00);
    pb_dir = 4'b0000;
    step("upleft_rel", 6);

    // commit UP, then down press coinciding with sync
    strobe("commit_up");
    chk("commit_up_dir", dir_o, 2'b00);
    pb_dir = 4'b0100;
    step("down2", 6);
    chk("down2_pulse", any_press_o, 1'b1);
    strobe("down2_sync");
    chk("down2_dir", dir_o, 2'b00);
    chk("down2_pend", dir_pending_o, 2'b00);
    pb_dir = 4'b0000;
    step("down2_rel", 6);

    // en dropped mid-debounce, sync ignored meanwhile
    do_reset();
    pb_mode = 1'b1;
    step("mode", 4);
    en = 1'b0;
    step("en_low", 10);
    sync = 1'b1;
    step("en_low_sync");
    sync = 1'b0;
    step("en_low", 9);
    en = 1'b1;
    step("en_resume");
    chk("en_resume_nopulse", mode_pulse_o, 1'b0);
    step("en_pulse");
    chk("en_mode_pulse", mode_pulse_o, 1'b1);
    pb_mode = 1'b0;
    pb_dir = 4'b1000;
    step("pre_rst", 7);
    strobe("pre_rst_sync");
    chk("pre_rst_dir", dir_o, 2'b00);
    pb_dir = 4'b0000;
    step("rel_mid", 4);
    do_reset();
    chk("async_dir", dir_o, 2'b11);
    chk("async_pend", dir_pending_o, 2'b11);
    step("post_rst", 10);

    // randomized phase with persistent button levels
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(5) == 0) pb_dir[b] = ~pb_dir[b];
      if ($urandom_range(7) == 0) pb_mode = ~pb_mode;
      if ($urandom_range(7) == 0) pb_obs = ~pb_obs;
      sync = ($urandom_range(7) == 0);
      step("rand");
    end
    sync = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
